// File: rtl/pow_var_pkg.sv
// Shared definitions for the variable-exponent power unit: FSM state encoding and default widths.
package pow_var_pkg;

    localparam int unsigned W_DEF  = 8;
    localparam int unsigned EW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pow_var_step.sv
// One square-and-multiply step: consumes exponent bit 0, squares the base, shifts the exponent.
module pow_var_step
    import pow_var_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned EW = EW_DEF
) (
    input  logic [W-1:0]  acc,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp,
    output logic [W-1:0]  acc_next,
    output logic [W-1:0]  base_next,
    output logic [EW-1:0] exp_next,
    output logic          last
);

    // Products are sized to W bits, so the upper half is simply dropped (mod 2^W).
    always_comb begin
        acc_next  = exp[0] ? acc * base : acc;
        base_next = base * base;
        exp_next  = exp >> 1;
        last      = (exp_next == '0);
    end

endmodule

// File: rtl/pow_var_en_multi_cycle.sv
// Multi-cycle res = n^e mod 2^W with clock enable and ready/valid request handshake.
// Define POW_VAR_FIXED_LATENCY_EN to make every calculation take exactly EW enabled cycles.
module pow_var_en_multi_cycle
    import pow_var_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          n_vld,
    output logic          n_rdy,
    input  logic [W-1:0]  n,
    input  logic [EW-1:0] e,
    output logic          res_vld,
    output logic [W-1:0]  res
);

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  base_q, base_d;
    logic [EW-1:0] exp_q, exp_d;
    logic          n_rdy_q, n_rdy_d;
    logic          res_vld_q, res_vld_d;

    logic [W-1:0]  acc_next, base_next;
    logic [EW-1:0] exp_next;
    logic          last;
    logic          step_done;

    pow_var_step #(
        .W  (W),
        .EW (EW)
    ) u_step (
        .acc       (acc_q),
        .base      (base_q),
        .exp       (exp_q),
        .acc_next  (acc_next),
        .base_next (base_next),
        .exp_next  (exp_next),
        .last      (last)
    );

`ifdef POW_VAR_FIXED_LATENCY_EN
    localparam int unsigned CW = $clog2(EW + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // The exponent keeps shifting in zeros after its top bit, so the extra steps leave acc unchanged.
    assign step_done = (cnt_q == CW'(EW - 1));
`else
    assign step_done = last;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        base_d  = base_q;
        exp_d   = exp_q;
`ifdef POW_VAR_FIXED_LATENCY_EN
        cnt_d   = cnt_q;
`endif
        if (clk_en) begin
            case (state_q)
                IDLE, DONE: begin
                    if (n_vld) begin
                        acc_d   = W'(1);
                        base_d  = n;
                        exp_d   = e;
                        state_d = CALC;
`ifdef POW_VAR_FIXED_LATENCY_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    acc_d  = acc_next;
                    base_d = base_next;
                    exp_d  = exp_next;
`ifdef POW_VAR_FIXED_LATENCY_EN
                    cnt_d  = cnt_q + 1'b1;
`endif
                    if (step_done) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        n_rdy_d   = (state_d != CALC);
        res_vld_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            n_rdy_q   <= 1'b1;
            res_vld_q <= 1'b0;
`ifdef POW_VAR_FIXED_LATENCY_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            n_rdy_q   <= n_rdy_d;
            res_vld_q <= res_vld_d;
`ifdef POW_VAR_FIXED_LATENCY_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Operand registers are always loaded on accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        base_q <= base_d;
        exp_q  <= exp_d;
    end

    assign n_rdy   = n_rdy_q;
    assign res_vld = res_vld_q;
    assign res     = acc_q;

endmodule
